// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one read/write master port between the fetch and data
//            ports, one transaction in flight, fetch never starves data.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter bit MEM_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    // fetch port (read-only)
    input  logic                if_valid,
    output logic                if_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic [1:0]          if_size,
    output logic [DATA_W-1:0]   if_data_read,
    output logic [1:0]          if_resp,
    // data port
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic                mem_req,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [1:0]          mem_size,
    input  logic [DATA_W-1:0]   mem_data_write,
    input  logic [DATA_W/8-1:0] mem_w_mask,
    output logic [DATA_W-1:0]   mem_data_read,
    output logic [1:0]          mem_resp,
    // shared downstream port
    output logic                rw_valid,
    input  logic                rw_ready,
    output logic                rw_req,
    output logic [ADDR_W-1:0]   rw_addr,
    output logic [1:0]          rw_size,
    output logic [DATA_W-1:0]   rw_data_write,
    output logic [DATA_W/8-1:0] rw_w_mask,
    input  logic [DATA_W-1:0]   rw_data_read,
    input  logic [1:0]          rw_resp,
    output logic [31:0]         conflict_cnt
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_GNT_IF  = 2'd1;
    localparam logic [1:0]  S_GNT_MEM = 2'd2;
    localparam logic        C_GNT_IF  = 1'b0;
    localparam logic        C_GNT_MEM = 1'b1;
    localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        r_last_gnt;
    logic [31:0] r_conflict_cnt;
    logic        w_conflict;
    logic        w_handshake;

    assign w_conflict   = (r_state == S_IDLE) && if_valid && mem_valid;
    assign w_handshake  = rw_valid && rw_ready;
    assign conflict_cnt = r_conflict_cnt;

    // Request fields and responses are steered purely by the current grant;
    // everything not belonging to the granted port is forced to zero.
    always_comb begin
        w_next_state  = r_state;
        rw_valid      = 1'b0;
        rw_req        = 1'b0;
        rw_addr       = '0;
        rw_size       = '0;
        rw_data_write = '0;
        rw_w_mask     = '0;
        if_ready      = 1'b0;
        if_data_read  = '0;
        if_resp       = '0;
        mem_ready     = 1'b0;
        mem_data_read = '0;
        mem_resp      = '0;
        case (r_state)
            S_IDLE: begin
                if (mem_valid && !if_valid) begin
                    w_next_state = S_GNT_MEM;
                end else if (if_valid && !mem_valid) begin
                    w_next_state = S_GNT_IF;
                end else if (if_valid && mem_valid) begin
                    w_next_state = (MEM_FIRST || (r_last_gnt == C_GNT_IF)) ? S_GNT_MEM : S_GNT_IF;
                end
            end
            S_GNT_IF: begin
                rw_valid = if_valid;
                rw_addr  = if_addr;
                rw_size  = if_size;
                if (if_valid && rw_ready) begin
                    if_ready     = 1'b1;
                    if_data_read = rw_data_read;
                    if_resp      = rw_resp;
                    w_next_state = S_IDLE;
                end
            end
            S_GNT_MEM: begin
                rw_valid      = mem_valid;
                rw_req        = mem_req;
                rw_addr       = mem_addr;
                rw_size       = mem_size;
                rw_data_write = mem_data_write;
                rw_w_mask     = mem_w_mask;
                if (mem_valid && rw_ready) begin
                    mem_ready     = 1'b1;
                    mem_data_read = rw_data_read;
                    mem_resp      = rw_resp;
                    w_next_state  = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_last_gnt     <= C_GNT_IF;
            r_conflict_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_handshake) begin
                r_last_gnt <= (r_state == S_GNT_MEM) ? C_GNT_MEM : C_GNT_IF;
            end
            if (w_conflict && (r_conflict_cnt != C_CNT_MAX)) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for mem_port_arbiter: two instances (data-first and round-robin)
// driven with random traffic and scored against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int MASK_W = DATA_W / 8;
    localparam int N_CYC  = 3000;

    typedef struct packed {
        logic              hs;
        logic              req;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] mask;
    } rw_t;

    typedef struct packed {
        logic              ifr;
        logic              memr;
        logic [DATA_W-1:0] ifd;
        logic [1:0]        ifresp;
        logic [DATA_W-1:0] memd;
        logic [1:0]        memresp;
        logic [31:0]       conf;
    } rsp_t;

    int errors = 0;
    int checks = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int inst, input string name,
                       input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL i%0d %s: got %0h expected %0h", inst, name, act, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam bit MF = (k == 0);

        logic              rst;
        logic              if_valid, if_ready;
        logic [ADDR_W-1:0] if_addr;
        logic [1:0]        if_size;
        logic [DATA_W-1:0] if_data_read;
        logic [1:0]        if_resp;
        logic              mem_valid, mem_ready, mem_req;
        logic [ADDR_W-1:0] mem_addr;
        logic [1:0]        mem_size;
        logic [DATA_W-1:0] mem_data_write, mem_data_read;
        logic [MASK_W-1:0] mem_w_mask;
        logic [1:0]        mem_resp;
        logic              rw_valid, rw_ready, rw_req;
        logic [ADDR_W-1:0] rw_addr;
        logic [1:0]        rw_size;
        logic [DATA_W-1:0] rw_data_write, rw_data_read;
        logic [MASK_W-1:0] rw_w_mask;
        logic [1:0]        rw_resp;
        logic [31:0]       conflict_cnt;
        bit                done = 1'b0;

        rw_t  rw_q[$];
        rsp_t rsp_q[$];

        mem_port_arbiter #(
            .ADDR_W    (ADDR_W),
            .DATA_W    (DATA_W),
            .MEM_FIRST (MF)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .if_valid       (if_valid),
            .if_ready       (if_ready),
            .if_addr        (if_addr),
            .if_size        (if_size),
            .if_data_read   (if_data_read),
            .if_resp        (if_resp),
            .mem_valid      (mem_valid),
            .mem_ready      (mem_ready),
            .mem_req        (mem_req),
            .mem_addr       (mem_addr),
            .mem_size       (mem_size),
            .mem_data_write (mem_data_write),
            .mem_w_mask     (mem_w_mask),
            .mem_data_read  (mem_data_read),
            .mem_resp       (mem_resp),
            .rw_valid       (rw_valid),
            .rw_ready       (rw_ready),
            .rw_req         (rw_req),
            .rw_addr        (rw_addr),
            .rw_size        (rw_size),
            .rw_data_write  (rw_data_write),
            .rw_w_mask      (rw_w_mask),
            .rw_data_read   (rw_data_read),
            .rw_resp        (rw_resp),
            .conflict_cnt   (conflict_cnt)
        );

        // Stimulus plus reference model: the model only tracks whether the
        // shared port is taken, by whom, and who was served last.
        initial begin : p_stim
            bit          busy, owner, last, hs_if, hs_mem;
            logic [31:0] conf, conf_prev;
            rw_t         ew;
            rsp_t        er;
            busy = 1'b0; owner = 1'b0; last = 1'b0;
            conf = '0; conf_prev = '0;
            rst = 1'b1;
            if_valid = 1'b0; if_addr = '0; if_size = '0;
            mem_valid = 1'b0; mem_req = 1'b0; mem_addr = '0; mem_size = '0;
            mem_data_write = '0; mem_w_mask = '0;
            rw_ready = 1'b0; rw_data_read = '0; rw_resp = '0;
            repeat (2) @(negedge clk);
            chk(k, "reset rw_valid", 200'(rw_valid), 200'(0));
            chk(k, "reset if_ready", 200'(if_ready), 200'(0));
            chk(k, "reset mem_ready", 200'(mem_ready), 200'(0));
            chk(k, "reset conflict_cnt", 200'(conflict_cnt), 200'(0));
            rst = 1'b0;
            hs_if = 1'b1; hs_mem = 1'b1;

            for (int c = 0; c < N_CYC; c++) begin
                @(posedge clk); #1;
                if (hs_if || !if_valid) begin
                    if_valid = ($urandom_range(0, 9) != 0);
                    if_addr  = {32'h0, 32'h8000_0000 + ($urandom & 32'h0000_fffc)};
                    if_size  = 2'($urandom);
                end
                if (hs_mem || !mem_valid) begin
                    mem_valid      = ($urandom_range(0, 4) < 3);
                    mem_req        = 1'($urandom);
                    mem_addr       = {$urandom, $urandom};
                    mem_size       = 2'($urandom);
                    mem_data_write = {$urandom, $urandom};
                    mem_w_mask     = 8'($urandom);
                end
                rw_ready     = ($urandom_range(0, 2) != 0);
                rw_data_read = {$urandom, $urandom};
                rw_resp      = 2'($urandom);

                @(negedge clk);
                hs_if = 1'b0; hs_mem = 1'b0;
                conf_prev = conf;
                if (!busy) begin
                    if (if_valid && mem_valid && conf != 32'hFFFF_FFFF) conf = conf + 1;
                    if (if_valid || mem_valid) begin
                        if (if_valid && mem_valid) owner = MF ? 1'b1 : !last;
                        else                        owner = mem_valid;
                        busy = 1'b1;
                    end
                end else if ((owner ? mem_valid : if_valid) && rw_ready) begin
                    ew = '0; er = '0;
                    ew.hs = 1'b1;
                    if (owner) begin
                        ew.req = mem_req; ew.addr = mem_addr; ew.size = mem_size;
                        ew.wdata = mem_data_write; ew.mask = mem_w_mask;
                        er.memr = 1'b1; er.memd = rw_data_read; er.memresp = rw_resp;
                        hs_mem = 1'b1;
                    end else begin
                        ew.addr = if_addr; ew.size = if_size;
                        er.ifr = 1'b1; er.ifd = rw_data_read; er.ifresp = rw_resp;
                        hs_if = 1'b1;
                    end
                    er.conf = conf;
                    rw_q.push_back(ew);
                    rsp_q.push_back(er);
                    busy = 1'b0;
                    last = owner;
                end
            end
            chk(k, "final conflict_cnt", 200'(conflict_cnt), 200'(conf_prev));
            chk(k, "conflicts seen", 200'(conf_prev != 0), 200'(1));

            // Asynchronous reset in the middle of whatever transaction is open.
            @(posedge clk); #1;
            rst = 1'b1;
            if_valid = 1'b0; mem_valid = 1'b1; mem_req = 1'b1;
            mem_addr = 64'h0000_0000_8000_1000; mem_w_mask = 8'hFF; rw_ready = 1'b0;
            #1;
            chk(k, "async rst rw_valid", 200'(rw_valid), 200'(0));
            chk(k, "async rst conflict_cnt", 200'(conflict_cnt), 200'(0));
            @(negedge clk); rst = 1'b0;
            @(posedge clk); #1;
            if_valid = 1'b1;
            #1;
            chk(k, "mem grant rw_valid", 200'(rw_valid), 200'(1));
            chk(k, "mem grant rw_addr", 200'(rw_addr), 200'(64'h0000_0000_8000_1000));
            chk(k, "mem grant rw_req", 200'(rw_req), 200'(1));
            @(negedge clk);
            rst = 1'b1;
            #1;
            chk(k, "rst in GNT_MEM rw_valid", 200'(rw_valid), 200'(0));
            chk(k, "rst in GNT_MEM readies", 200'({if_ready, mem_ready}), 200'(0));
            chk(k, "rst in GNT_MEM conflict_cnt", 200'(conflict_cnt), 200'(0));
            @(negedge clk); rst = 1'b0;
            @(negedge clk);
            done = 1'b1;
        end

        initial begin : p_mon
            rw_t  ew;
            rsp_t er;
            bit   hw, hr;
            forever begin
                @(negedge clk); #1;
                hw = (rw_q.size() != 0);
                ew = '0;
                if (hw) ew = rw_q.pop_front();
                if (hw || (rw_valid && rw_ready))
                    chk(k, "rw request", 200'({rw_valid & rw_ready, rw_req, rw_addr, rw_size,
                                               rw_data_write, rw_w_mask}), 200'(ew));
                hr = (rsp_q.size() != 0);
                er = '0;
                if (hr) er = rsp_q.pop_front();
                if (hr || if_ready || mem_ready)
                    chk(k, "response", 200'({if_ready, mem_ready, if_data_read, if_resp,
                                             mem_data_read, mem_resp, conflict_cnt}), 200'(er));
            end
        end
    end

    initial begin : p_main
        wait (g_inst[0].done && g_inst[1].done);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : p_watchdog
        #1_000_000;
        $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
